prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program sequencer for `simple_processor`. It fetches 16-bit instruction words from a synchronous instruction ROM over an address range, presents each word on the processor's `DIN` with a one-cycle `run` strobe, and waits for the processor's `done`. It reports completion, instruction count and a watchdog timeout fault. It replaces hand-driven `run`/`DIN` stimulus at system level.

## Interface

- `ADDR_WIDTH`, 8: instruction ROM address width.
- `TIMEOUT`, 64: maximum WAIT cycles per instruction before fault (≥2).
- `clk_50MHz` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin program; sampled only in IDLE.
- `abort` in 1: return to IDLE from any state except FAULT.
- `start_addr` in ADDR_WIDTH: first instruction address; sampled with `start`.
- `end_addr` in ADDR_WIDTH: last instruction address (inclusive); sampled with `start`.
- `mem_addr` out ADDR_WIDTH: ROM address, equal to `pc`.
- `mem_rd` out 1: ROM read enable.
- `mem_rdata` in 16: ROM data, valid the cycle after `mem_rd`.
- `proc_run` out 1: one-cycle issue strobe to the processor.
- `proc_din` out 16: instruction word to the processor (`DIN`).
- `proc_done` in 1: processor completion, single-cycle pulse.
- `busy` out 1: high in every state except IDLE and FAULT.
- `prog_done` out 1: one-cycle pulse when the last instruction completes.
- `fault` out 1: sticky watchdog fault.
- `instr_count` out 16: instructions completed since the last `start`.

## Operation

- States: IDLE, FETCH, LOAD, ISSUE, WAIT, FINISH, FAULT.
- **IDLE**
  - If `start`=1: `pc`←`start_addr`, `last`←`end_addr`, `instr_count`←0, go to FETCH.
  - `start` is ignored in all other states.
- **FETCH**: `mem_rd`=1. Go to LOAD.
- **LOAD**: `ir`←`mem_rdata`. Go to ISSUE.
- **ISSUE**: `proc_run`=1, `timer`←0. Go to WAIT.
- **WAIT**: `proc_done` is sampled only in this state.
  - If `proc_done`=1:
    - `instr_count`←`instr_count`+1, saturating at 0xFFFF.
    - If `pc`==`last`, go to FINISH.
    - Otherwise `pc`←`pc`+1 (modulo 2^ADDR_WIDTH) and go to FETCH.
  - Else if `timer`==TIMEOUT−1, go to FAULT.
  - Else `timer`←`timer`+1.
- **FINISH**: `prog_done`=1 for one cycle. Go to IDLE.
- **FAULT**: `fault`=1. Exits only on `reset`. `abort` and `start` are ignored.
- **Address wrap**: `end_addr` < `start_addr` runs through the wrap, e.g. 0xFE, 0xFF, 0x00, 0x01. `start_addr`==`end_addr` executes exactly one instruction.
- **Priority**: `reset` > `abort` > normal transitions.
  - `abort` in WAIT discards any coincident `proc_done`: the count is not incremented and there is no `prog_done`.
  - `abort` in FINISH still emits that cycle's `prog_done` pulse, then goes to IDLE.
- `proc_done` outside WAIT, including in the ISSUE cycle, is ignored.
- `proc_din` holds `ir` at all times. It is stable from the ISSUE cycle until the next LOAD.

## Timing

- **Reset values**:
  - State IDLE; `pc`, `last`, `ir`, `timer`, `instr_count` all 0.
  - `mem_addr`=0, `mem_rd`=0, `proc_run`=0, `proc_din`=0, `busy`=0, `prog_done`=0, `fault`=0.
- **Reset mid-operation**: all of the above in the next cycle. No further `proc_run` is issued.
- **Start to first issue**: `start` sampled at edge 0, FETCH in cycle 1, LOAD in cycle 2, `proc_run` in cycle 3.
- **Per instruction**: 3 + k cycles, where `proc_done` arrives in the k-th WAIT cycle (k ≥ 1). Back-to-back minimum is 4 cycles between `proc_run` pulses.
- **Completion**: `prog_done` is asserted in the cycle after the WAIT cycle that samples the last `proc_done`. `busy` drops in the cycle after `prog_done`.
- **Fault**: asserted in the cycle after TIMEOUT WAIT cycles without `proc_done`.
- `proc_run` is never high on two consecutive cycles.

## Test plan

- **Nominal program**
  - Stimulus: ROM[0..3] = 0x101C, 0x0200, 0x32FF, 0x52FF; start_addr=0, end_addr=3; processor model pulses done 2 cycles after run.
  - Response: four `proc_run` pulses with `proc_din` equal to those words in order, 5 cycles apart; one `prog_done`; `instr_count`=4; `fault`=0.
- **Watchdog**
  - Stimulus: TIMEOUT=16; model never asserts done.
  - Response: one `proc_run`; `fault`=1 exactly 16 cycles after the WAIT entry; `busy`=0; `start` then has no effect; `reset` clears `fault`.
- **Wrap-around**
  - Stimulus: start_addr=0xFE, end_addr=0x01.
  - Response: `mem_addr` sequence 0xFE, 0xFF, 0x00, 0x01; `instr_count`=4.
- **Single instruction**
  - Stimulus: start_addr=end_addr=0x05.
  - Response: one `proc_run`, then `prog_done`.
- **Abort with coincident done**
  - Stimulus: `abort` asserted in WAIT on the same cycle as `proc_done`.
  - Response: IDLE next cycle; `instr_count` unchanged; no `prog_done`; no further `proc_run`.
- **Reset mid-WAIT and edge events**
  - Stimulus: `reset` asserted in WAIT; `proc_done` asserted during the ISSUE cycle.
  - Response: all outputs at reset values next cycle; the done during ISSUE is ignored and the sequencer still waits for a done in WAIT.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches instruction words from a synchronous ROM and issues
// them one at a time to simple_processor, with a per-instruction watchdog.
module prog_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [15:0]           mem_rdata,
  output logic                  proc_run,
  output logic [15:0]           proc_din,
  input  logic                  proc_done,
  output logic                  busy,
  output logic                  prog_done,
  output logic                  fault,
  output logic [15:0]           instr_count
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [15:0]             ir_q, ir_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [15:0]             count_q, count_d;

  // State and datapath registers
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      ir_q    <= 16'h0000;
      timer_q <= '0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      ir_q    <= ir_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; abort overrides everything except FAULT
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    ir_d    = ir_q;
    timer_d = timer_q;
    count_d = count_q;
    if (abort && (state_q != S_FAULT)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = start_addr;
            last_d  = end_addr;
            count_d = 16'h0000;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          ir_d    = mem_rdata;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (proc_done) begin
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end else begin
              count_d = count_q;
            end
            if (pc_q == last_q) begin
              state_d = S_FINISH;
            end else begin
              pc_d    = pc_q + ADDR_WIDTH'(1);
              state_d = S_FETCH;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_FAULT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_FINISH: state_d = S_IDLE;
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    mem_rd    = 1'b0;
    proc_run  = 1'b0;
    busy      = 1'b1;
    prog_done = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_FETCH:  mem_rd = 1'b1;
      S_LOAD:   busy = 1'b1;
      S_ISSUE:  proc_run = 1'b1;
      S_WAIT:   busy = 1'b1;
      S_FINISH: prog_done = 1'b1;
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  assign mem_addr    = pc_q;
  assign proc_din    = ir_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table-driven programs, randomized programs
// against a transaction-level model, and hand-written watchdog/abort/reset sequences.
module tb_prog_sequencer;
  localparam int AW = 8;
  localparam int TO = 16;

  logic           clk_50MHz = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [AW-1:0]  start_addr = 8'h00;
  logic [AW-1:0]  end_addr = 8'h00;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd;
  logic [15:0]    mem_rdata = 16'h0000;
  logic           proc_run;
  logic [15:0]    proc_din;
  logic           proc_done = 1'b0;
  logic           busy;
  logic           prog_done;
  logic           fault;
  logic [15:0]    instr_count;

  prog_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .proc_run   (proc_run),
    .proc_din   (proc_din),
    .proc_done  (proc_done),
    .busy       (busy),
    .prog_done  (prog_done),
    .fault      (fault),
    .instr_count(instr_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Synchronous instruction ROM: data valid the cycle after the read
  logic [15:0] rom [0:255];
  always @(posedge clk_50MHz) if (mem_rd) mem_rdata <= rom[mem_addr];

  typedef struct {
    logic [7:0] sa;
    logic [7:0] ea;
    int         dly;
    int         exp_n;
  } vec_t;
  vec_t vecs [6];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit auto_en = 1'b0;
  int dly = 1;
  int done_at = -1;
  bit prev_run = 1'b0;
  int pd_cnt = 0;
  int pd_cyc = -1;
  logic [15:0] din_q [$];
  int          run_cyc_q [$];
  logic [7:0]  addr_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs after the edge, then drive the processor model
  task automatic clk_cycle();
    @(posedge clk_50MHz);
    #1;
    cyc++;
    if (proc_run) begin
      chk("run_gap", int'(prev_run), 0);
      din_q.push_back(proc_din);
      run_cyc_q.push_back(cyc);
      if (auto_en) done_at = cyc + dly;
    end
    prev_run = proc_run;
    if (mem_rd) addr_q.push_back(mem_addr);
    if (prog_done) begin
      pd_cnt++;
      pd_cyc = cyc;
    end
    proc_done = auto_en && (cyc == done_at);
  endtask

  task automatic clear_log();
    din_q.delete();
    run_cyc_q.delete();
    addr_q.delete();
    pd_cnt = 0;
    pd_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_rd"}, int'(mem_rd), 0);
    chk({tag, "_proc_run"}, int'(proc_run), 0);
    chk({tag, "_proc_din"}, int'(proc_din), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_prog_done"}, int'(prog_done), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_count"}, int'(instr_count), 0);
  endtask

  // Runs a whole program and checks it against the address-range model
  task automatic run_prog(input logic [7:0] sa, input logic [7:0] ea, input int d, input int exp_n);
    int t1;
    int budget;
    int last;
    logic [7:0] a;
    clear_log();
    auto_en = 1'b1;
    dly = d;
    done_at = -1;
    start_addr = sa;
    end_addr = ea;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    t1 = cyc;
    budget = 0;
    while (pd_cnt == 0 && budget < 3000) begin
      clk_cycle();
      budget++;
    end
    chk("prog_done_seen", pd_cnt, 1);
    clk_cycle();
    chk("prog_done_pulse", int'(prog_done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("run_count", run_cyc_q.size(), exp_n);
    chk("fetch_count", addr_q.size(), exp_n);
    chk("instr_count", int'(instr_count), exp_n);
    chk("fault_clear", int'(fault), 0);
    if (run_cyc_q.size() > 0) begin
      chk("first_issue", run_cyc_q[0] - t1, 2);
      last = run_cyc_q.size() - 1;
      chk("done_latency", pd_cyc - run_cyc_q[last], d + 1);
    end
    for (int i = 0; i < run_cyc_q.size(); i++) begin
      a = sa + 8'(i);
      chk("proc_din", int'(din_q[i]), int'(rom[a]));
      if (i < addr_q.size()) chk("mem_addr", int'(addr_q[i]), int'(a));
      if (i > 0) chk("issue_spacing", run_cyc_q[i] - run_cyc_q[i-1], 3 + d);
    end
    auto_en = 1'b0;
  endtask

  initial begin
    int t1;
    int nrun;
    logic [7:0] sa;
    int span;
    int d;

    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h101C;
    rom[1] = 16'h0200;
    rom[2] = 16'h32FF;
    rom[3] = 16'h52FF;
    rom[8'h50] = 16'hA5A5;

    vecs[0] = '{sa: 8'h00, ea: 8'h03, dly: 2, exp_n: 4};
    vecs[1] = '{sa: 8'hFE, ea: 8'h01, dly: 2, exp_n: 4};
    vecs[2] = '{sa: 8'h05, ea: 8'h05, dly: 1, exp_n: 1};
    vecs[3] = '{sa: 8'h10, ea: 8'h12, dly: 1, exp_n: 3};
    vecs[4] = '{sa: 8'h20, ea: 8'h20, dly: 4, exp_n: 1};
    vecs[5] = '{sa: 8'hFF, ea: 8'h00, dly: 3, exp_n: 2};

    // Power-on reset
    reset = 1'b1;
    clk_cycle();
    clk_cycle();
    check_reset_outputs("por");
    reset = 1'b0;
    clk_cycle();

    for (int i = 0; i < 6; i++) run_prog(vecs[i].sa, vecs[i].ea, vecs[i].dly, vecs[i].exp_n);

    for (int i = 0; i < 20; i++) begin
      sa = 8'($urandom);
      span = int'($urandom_range(0, 5));
      d = int'($urandom_range(1, 4));
      run_prog(sa, sa + 8'(span), d, span + 1);
    end

    // Watchdog: done never arrives
    clear_log();
    auto_en = 1'b0;
    start_addr = 8'h30;
    end_addr = 8'h31;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 18) clk_cycle();
    chk("wd_no_fault_yet", int'(fault), 0);
    chk("wd_busy_in_wait", int'(busy), 1);
    clk_cycle();
    chk("wd_fault", int'(fault), 1);
    chk("wd_busy", int'(busy), 0);
    chk("wd_runs", run_cyc_q.size(), 1);
    start = 1'b1;
    abort = 1'b1;
    clk_cycle();
    start = 1'b0;
    abort = 1'b0;
    clk_cycle();
    clk_cycle();
    chk("wd_sticky", int'(fault), 1);
    chk("wd_no_refetch", addr_q.size(), 1);
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    chk("wd_reset_clears", int'(fault), 0);
    clk_cycle();

    // Done during ISSUE is ignored; abort with coincident done in WAIT
    clear_log();
    start_addr = 8'h40;
    end_addr = 8'h42;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    t1 = cyc;
    clk_cycle();
    clk_cycle();
    chk("ab_issue", int'(proc_run), 1);
    proc_done = 1'b1;
    clk_cycle();
    chk("ab_issue_done_ignored", int'(mem_rd), 0);
    chk("ab_wait_busy", int'(busy), 1);
    chk("ab_count0", int'(instr_count), 0);
    clk_cycle();
    chk("ab_still_wait", int'(mem_rd), 0);
    proc_done = 1'b1;
    clk_cycle();
    chk("ab_refetch", int'(mem_rd), 1);
    chk("ab_next_addr", int'(mem_addr), 8'h41);
    chk("ab_count1", int'(instr_count), 1);
    clk_cycle();
    clk_cycle();
    clk_cycle();
    proc_done = 1'b1;
    abort = 1'b1;
    clk_cycle();
    abort = 1'b0;
    chk("ab_idle", int'(busy), 0);
    chk("ab_count_kept", int'(instr_count), 1);
    nrun = run_cyc_q.size();
    for (int i = 0; i < 8; i++) clk_cycle();
    chk("ab_no_prog_done", pd_cnt, 0);
    chk("ab_no_more_runs", run_cyc_q.size(), nrun);
    chk("ab_total_runs", nrun, 2);

    // Reset in the middle of WAIT
    clear_log();
    start_addr = 8'h50;
    end_addr = 8'h55;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) clk_cycle();
    chk("rst_loaded_din", int'(proc_din), 16'hA5A5);
    reset = 1'b1;
    clk_cycle();
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    nrun = run_cyc_q.size();
    for (int i = 0; i < 6; i++) clk_cycle();
    chk("rst_no_more_runs", run_cyc_q.size(), nrun);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
